// File: rtl/uart_word_rx.sv
// uart_word_rx: 8N1 UART receiver that reports each byte and pairs
// consecutive bytes into 16-bit words, low byte first.
// Optional build macro UART_WORD_TIMEOUT_EN: drop a pending low byte after
// TIMEOUT_SYMS idle symbol periods so the host can resynchronise.
module uart_word_rx #(
  parameter int SCW          = 16,
  parameter int sym_cnt      = 40000,
  parameter int TIMEOUT_SYMS = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_serial,
  output logic [7:0]  rx_dat,
  output logic        rx_stb,
  output logic [15:0] word_dat,
  output logic        word_stb,
  output logic        frame_err,
  output logic        rx_busy
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } state_t;

  localparam logic [SCW-1:0] CNT_ZERO    = SCW'(32'sd0);
  localparam logic [SCW-1:0] CNT_ONE     = SCW'(32'sd1);
  localparam logic [SCW-1:0] SYM_RELOAD  = SCW'(sym_cnt - 32'sd1);
  localparam logic [SCW-1:0] HALF_RELOAD = SCW'(sym_cnt / 32'sd2 - 32'sd1);

  logic           sync1_r;
  logic           rxs_r;
  state_t         state_r, state_s;
  logic [SCW-1:0] cnt_r, cnt_s;
  logic [2:0]     bit_r, bit_s;
  logic [7:0]     shreg_r, shreg_s;
  logic           byte_done_s;
  logic           ferr_s;
  logic           half_r;
  logic [7:0]     lo_r;
  logic           tmo_hit_s;

  // Two-flop synchroniser for the asynchronous line; idles high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r <= 1'b1;
      rxs_r   <= 1'b1;
    end else begin
      sync1_r <= rx_serial;
      rxs_r   <= sync1_r;
    end
  end

  // FSM state, symbol counter, bit index and shift register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= CNT_ZERO;
      bit_r   <= 3'd0;
      shreg_r <= 8'd0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      bit_r   <= bit_s;
      shreg_r <= shreg_s;
    end
  end

  // Next-state logic: mid-symbol sampling of start, data and stop bits.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    bit_s       = bit_r;
    shreg_s     = shreg_r;
    byte_done_s = 1'b0;
    ferr_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!rxs_r) begin
          state_s = ST_START;
          cnt_s   = HALF_RELOAD;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (cnt_r == CNT_ZERO) begin
          if (!rxs_r) begin
            state_s = ST_DATA;
            cnt_s   = SYM_RELOAD;
            bit_s   = 3'd0;
          end else begin
            // Line went back high before mid start bit: a glitch.
            state_s = ST_IDLE;
          end
        end else begin
          cnt_s = cnt_r - CNT_ONE;
        end
      end
      ST_DATA: begin
        if (cnt_r == CNT_ZERO) begin
          shreg_s = {rxs_r, shreg_r[7:1]};
          cnt_s   = SYM_RELOAD;
          if (bit_r == 3'd7) begin
            state_s = ST_STOP;
          end else begin
            bit_s = bit_r + 3'd1;
          end
        end else begin
          cnt_s = cnt_r - CNT_ONE;
        end
      end
      ST_STOP: begin
        if (cnt_r == CNT_ZERO) begin
          if (rxs_r) begin
            byte_done_s = 1'b1;
            state_s     = ST_IDLE;
          end else begin
            ferr_s  = 1'b1;
            state_s = ST_BREAK;
          end
        end else begin
          cnt_s = cnt_r - CNT_ONE;
        end
      end
      ST_BREAK: begin
        // A held-low line must return high before a new start is accepted.
        if (rxs_r) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_BREAK;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

`ifdef UART_WORD_TIMEOUT_EN
  localparam int TSW = $clog2(TIMEOUT_SYMS + 32'sd1);
  localparam logic [TSW-1:0] TSYM_ZERO = TSW'(32'sd0);
  localparam logic [TSW-1:0] TSYM_ONE  = TSW'(32'sd1);
  localparam logic [TSW-1:0] TSYM_LAST = TSW'(TIMEOUT_SYMS - 32'sd1);

  logic [SCW-1:0] tmo_clk_r;
  logic [TSW-1:0] tmo_sym_r;
  logic           tmo_run_s;

  assign tmo_run_s = half_r && (state_r == ST_IDLE);
  assign tmo_hit_s = tmo_run_s && (tmo_clk_r == SYM_RELOAD) && (tmo_sym_r == TSYM_LAST);

  // Idle-time counter in symbol periods while a low byte is pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_clk_r <= CNT_ZERO;
      tmo_sym_r <= TSYM_ZERO;
    end else if (!tmo_run_s || tmo_hit_s) begin
      tmo_clk_r <= CNT_ZERO;
      tmo_sym_r <= TSYM_ZERO;
    end else if (tmo_clk_r == SYM_RELOAD) begin
      tmo_clk_r <= CNT_ZERO;
      tmo_sym_r <= tmo_sym_r + TSYM_ONE;
    end else begin
      tmo_clk_r <= tmo_clk_r + CNT_ONE;
    end
  end
`else
  // Without the timer the pairing never expires; TIMEOUT_SYMS is positive,
  // so this is constantly false.
  assign tmo_hit_s = (TIMEOUT_SYMS < 32'sd0);
`endif

  // Registered outputs and low/high byte pairing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_dat    <= 8'd0;
      rx_stb    <= 1'b0;
      word_dat  <= 16'd0;
      word_stb  <= 1'b0;
      frame_err <= 1'b0;
      rx_busy   <= 1'b0;
      half_r    <= 1'b0;
      lo_r      <= 8'd0;
    end else begin
      rx_stb    <= byte_done_s;
      word_stb  <= byte_done_s && half_r;
      frame_err <= ferr_s;
      rx_busy   <= (state_s != ST_IDLE);
      if (byte_done_s) begin
        rx_dat <= shreg_r;
        if (half_r) begin
          word_dat <= {shreg_r, lo_r};
          half_r   <= 1'b0;
        end else begin
          lo_r   <= shreg_r;
          half_r <= 1'b1;
        end
      end else if (ferr_s || tmo_hit_s) begin
        half_r <= 1'b0;
      end
    end
  end

endmodule

// File: doc/uart_word_rx.md
Name: uart_word_rx

Overview:
- UART receive path: host -> FPGA over fpga_rx, the reverse direction of the existing acia_tx dump link.
- Deserialises 8N1 bytes at the same symbol rate as the transmitter.
- Reports each byte and pairs consecutive bytes into 16-bit words, low byte first, matching the byte order the dump path transmits.
- Feeds command/config words to the capture and dispatcher logic.

Parameters:
- SCW, 16, width of the symbol-rate counter; must hold sym_cnt-1.
- sym_cnt, 40000, clocks per symbol (clk_freq / sym_rate; 48 MHz / 1200).
- TIMEOUT_SYMS, 20, idle symbol periods after a low byte before the pending low byte is dropped (UART_WORD_TIMEOUT_EN only).

Ports:
- clk  input  1  system clock
- rst  input  1  reset; asynchronous, active-high
- rx_serial  input  1  UART line, idle high, asynchronous to clk
- rx_dat  output  8  last received byte
- rx_stb  output  1  one-cycle pulse: rx_dat valid
- word_dat  output  16  {high byte, low byte} of last completed pair
- word_stb  output  1  one-cycle pulse: word_dat valid
- frame_err  output  1  one-cycle pulse: stop bit sampled low
- rx_busy  output  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset (async, rst=1): sync flops=1, FSM=IDLE, counters=0, half=0; rx_dat=0, word_dat=0, rx_stb=0, word_stb=0, frame_err=0, rx_busy=0. Reset mid-frame aborts the frame with no pulse.
- rx_serial passes through a 2-flop synchroniser; the FSM sees only the synchronised value rxs.
- IDLE:
  - rxs==0 -> START; load cnt=sym_cnt/2-1.
- START:
  - cnt decrements each clock.
  - At cnt==0: rxs==0 -> DATA, cnt=sym_cnt-1, bit=0.
  - At cnt==0: rxs==1 -> IDLE (glitch rejected, no pulse).
- DATA:
  - At cnt==0: shift rxs into shreg, LSB first; bit++; reload cnt=sym_cnt-1.
  - After bit 7 is sampled -> STOP.
- STOP:
  - At cnt==0: rxs==1 -> rx_dat<=shreg, rx_stb=1 next cycle, -> IDLE.
  - At cnt==0: rxs==0 -> frame_err=1 next cycle, byte discarded, half<=0, -> BREAK.
- BREAK:
  - Wait for rxs==1, then -> IDLE. A held-low line never produces bytes.
- Sample points are mid-symbol. The stop bit is sampled sym_cnt/2 + 9*sym_cnt clocks after the START entry. Synchroniser adds 2 cycles.
- Word assembly, evaluated in the cycle a valid byte completes:
  - half==0: lo<=byte, half<=1.
  - half==1: word_dat<={byte, lo}, word_stb=1 in the same cycle as rx_stb, half<=0.
- rx_dat and word_dat hold their values until overwritten. No ack and no backpressure: the consumer must take each pulse.
- Back-to-back frames: a start edge is accepted in the cycle the FSM returns to IDLE, with no dead symbol.
- cnt arithmetic is SCW-bit unsigned. sym_cnt must be >= 4.

Optional Feature:
- Macro: UART_WORD_TIMEOUT_EN.
- Defined:
  - A symbol counter runs while half==1 and FSM==IDLE; it clears on each START entry.
  - On reaching TIMEOUT_SYMS symbol periods, half<=0 and the pending low byte is silently dropped.
  - The next byte becomes the low byte, which resynchronises the host after a lost byte.
- Undefined:
  - No timer; pairing persists indefinitely until a framing error or reset.

Test Plan (sym_cnt=16, TIMEOUT_SYMS=20):
- Send 0xA5, 8N1 -> rx_stb once with rx_dat=0xA5, 154 (+/-1) clocks after the start edge; word_stb stays 0; frame_err=0.
- Send 0x34 then 0x12 back-to-back -> two rx_stb pulses; word_stb coincident with the second, word_dat=0x1234.
- 4-clock low glitch on an idle line -> no rx_stb, no frame_err; rx_busy high for about 10 clocks, then IDLE.
- Send 0x55 with its stop bit forced low, hold low 40 clocks, release, send 0x01, 0x02 -> frame_err pulse once; then word_dat=0x0201 (pending pairing cleared).
- Assert rst during bit 4 of 0xFF, release, send 0x0F -> rx_stb with rx_dat=0x0F; all outputs 0 during reset.
- UART_WORD_TIMEOUT_EN:
  - Send 0x11, idle 25 symbols, send 0x22, 0x33 -> word_dat=0x3322.
  - Same stimulus with the macro undefined -> word_dat=0x2211.
